// File: rtl/request_dispatcher_pkg.sv
// Shared definitions for the request dispatcher slice.
//   - op-code constants understood by operation_unit
//   - FSM state encoding used by request_dispatcher
package request_dispatcher_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_SHL2 = 2'b01;
  localparam logic [1:0] OP_ROR2 = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   push, wr_data   write request and data; ignored while full
//   pop             read request; ignored while empty
//   rd_data         head entry (valid only while !empty)
//   count           entries held, 0..DEPTH
//   full, empty     occupancy flags derived from count
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; count/pointers define
  // which entries are meaningful, and unreset arrays map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/request_dispatcher.sv
// Upstream stage of operation_unit. Queues user requests, issues them one
// at a time with a single-cycle op_start pulse, waits for an edge on
// ack_toggle, and recovers via a watchdog if the acknowledge never comes.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   req_valid/req_ready   user request handshake (ready = FIFO not full)
//   req_op, req_data      request payload
//   op_code, data_in      registered payload to operation_unit
//   op_start              one-cycle issue pulse
//   ack_toggle            completion indication, one per edge
//   busy                  FSM is not IDLE
//   fifo_count            entries currently queued
//   timeout_err           one-cycle pulse on watchdog expiry
module request_dispatcher
  import request_dispatcher_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [OP_W-1:0]          req_op,
  input  logic [DATA_W-1:0]        req_data,
  output logic [OP_W-1:0]          op_code,
  output logic [DATA_W-1:0]        data_in,
  output logic                     op_start,
  input  logic                     ack_toggle,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     timeout_err
);

  localparam int ENTRY_W = OP_W + DATA_W;
  localparam int WDOG_W  = $clog2(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  state_e              state, state_nxt;
  logic [WDOG_W-1:0]   wdog, wdog_nxt;
  logic                ack_seen, ack_seen_nxt;
  logic                op_start_nxt;
  logic                timeout_nxt;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  head;

  assign req_ready = !fifo_full;
  assign busy      = (state != IDLE);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (req_valid && req_ready),
    .wr_data ({req_op, req_data}),
    .pop     (fifo_pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    wdog_nxt     = wdog;
    ack_seen_nxt = ack_seen;
    op_start_nxt = 1'b0;
    timeout_nxt  = 1'b0;
    fifo_pop     = 1'b0;
    case (state)
      IDLE: begin
        // Edges arriving while nothing is outstanding are absorbed.
        ack_seen_nxt = ack_toggle;
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          op_start_nxt = 1'b1;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        ack_seen_nxt = ack_toggle;
        wdog_nxt     = '0;
        state_nxt    = WAIT_ACK;
      end
      WAIT_ACK: begin
        // The ack check comes first so a completion on the expiry cycle wins.
        if (ack_toggle != ack_seen) begin
          ack_seen_nxt = ack_toggle;
          state_nxt    = IDLE;
        end else if (wdog == WDOG_LAST) begin
          timeout_nxt  = 1'b1;
          ack_seen_nxt = ack_toggle;
          state_nxt    = IDLE;
        end else begin
          wdog_nxt = wdog + WDOG_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wdog        <= '0;
      ack_seen    <= ack_toggle;  // resync so the first edge after reset is real
      op_start    <= 1'b0;
      timeout_err <= 1'b0;
      op_code     <= '0;
      data_in     <= '0;
    end else begin
      state       <= state_nxt;
      wdog        <= wdog_nxt;
      ack_seen    <= ack_seen_nxt;
      op_start    <= op_start_nxt;
      timeout_err <= timeout_nxt;
      if (fifo_pop) begin
        op_code <= head[ENTRY_W-1:DATA_W];
        data_in <= head[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_request_dispatcher.sv
// Directed bench for request_dispatcher with an issue scoreboard.
module tb_request_dispatcher;
  import request_dispatcher_pkg::*;

  localparam int DATA_W  = 8;
  localparam int OP_W    = 2;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int ENTRY_W = OP_W + DATA_W;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic [OP_W-1:0]        req_op = '0;
  logic [DATA_W-1:0]      req_data = '0;
  logic [OP_W-1:0]        op_code;
  logic [DATA_W-1:0]      data_in;
  logic                   op_start;
  logic                   ack_toggle = 1'b0;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   timeout_err;

  request_dispatcher #(
    .DATA_W (DATA_W), .OP_W (OP_W), .DEPTH (DEPTH), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_data    (req_data),
    .op_code     (op_code),
    .data_in     (data_in),
    .op_start    (op_start),
    .ack_toggle  (ack_toggle),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int issue_cnt = 0;
  int to_cnt    = 0;
  logic               op_start_q = 1'b0;
  logic [ENTRY_W-1:0] sb [$];
  logic [ENTRY_W-1:0] exp_e;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue monitor: every op_start pulse must match the oldest accepted request.
  always @(negedge clk) begin
    if (timeout_err) to_cnt++;
    if (op_start) begin
      issue_cnt++;
      check("op_start_single_cycle", op_start_q, 0);
      check("issue_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_e = sb.pop_front();
        check("issue_op", op_code, exp_e[ENTRY_W-1:DATA_W]);
        check("issue_data", data_in, exp_e[DATA_W-1:0]);
      end
    end
    op_start_q = op_start;
  end

  // Every bench step lands 1 time unit after the falling edge, after the monitor.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] data);
    logic acc;
    acc       = req_ready;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    @(posedge clk);
    if (acc) sb.push_back({op, data});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_issue(input int target);
    for (int c = 0; c < 64 && issue_cnt < target; c++) tick();
    check("issue_arrived", issue_cnt >= target, 1);
  endtask

  // Called on the tick an issue was seen: step into WAIT_ACK, then complete it.
  task automatic flip_ack();
    tick();
    ack_toggle = ~ack_toggle;
    tick();
  endtask

  task automatic serve(input int target);
    wait_issue(target);
    flip_ack();
  endtask

  initial begin
    int base;
    int ic;

    // Reset state
    repeat (2) tick();
    check("rst_op_code", op_code, 0);
    check("rst_data_in", data_in, 0);
    check("rst_op_start", op_start, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", req_ready, 1);
    rst = 1'b0;
    tick();

    // Single request and first-issue latency
    push(OP_SHL2, 8'hCC);
    check("lat_e0_op_start", op_start, 0);
    check("lat_e0_count", fifo_count, 1);
    tick();
    check("lat_e1_op_start", op_start, 1);
    check("lat_e1_busy", busy, 1);
    tick();
    check("lat_e2_op_start", op_start, 0);
    check("lat_e2_busy", busy, 1);
    ack_toggle = ~ack_toggle;
    tick();
    check("single_done_busy", busy, 0);
    check("single_no_timeout", to_cnt, 0);

    // Fill to full while the first entry waits for its ack
    base = issue_cnt;
    push(OP_NOP,  8'hAA);
    push(OP_SHL2, 8'hCC);
    push(OP_ROR2, 8'hB3);
    push(OP_INV,  8'h55);
    push(OP_SHL2, 8'h11);
    check("full_count", fifo_count, 4);
    check("full_ready", req_ready, 0);
    push(OP_NOP,  8'hEE);
    check("full_ignored_count", fifo_count, 4);
    check("full_one_issued", issue_cnt, base + 1);
    for (int i = 0; i < 5; i++) begin
      wait_issue(base + 1 + i);
      repeat (3) tick();
      check("held_until_ack", issue_cnt, base + 1 + i);
      ack_toggle = ~ack_toggle;
      tick();
    end
    tick();
    check("drain_count", fifo_count, 0);
    check("drain_busy", busy, 0);
    check("drain_sb", sb.size(), 0);
    check("drain_no_timeout", to_cnt, 0);

    // Push and pop on the same edge at count=2, pointers past the wrap
    base = issue_cnt;
    push(OP_INV,  8'h01);
    push(OP_ROR2, 8'h02);
    push(OP_NOP,  8'h03);
    check("pp_pre_count", fifo_count, 2);
    ack_toggle = ~ack_toggle;
    tick();
    check("pp_idle", busy, 0);
    push(OP_SHL2, 8'h04);
    check("pp_same_edge_count", fifo_count, 2);
    check("pp_issued", issue_cnt, base + 2);
    for (int i = 2; i <= 4; i++) serve(base + i);
    check("pp_drain_count", fifo_count, 0);
    check("pp_drain_sb", sb.size(), 0);

    // Watchdog expiry, then the next queued request issues normally
    base = issue_cnt;
    push(OP_ROR2, 8'h0F);
    push(OP_SHL2, 8'h3C);
    wait_issue(base + 1);
    repeat (16) tick();
    check("wd_pre_timeout", timeout_err, 0);
    check("wd_pre_busy", busy, 1);
    tick();
    check("wd_timeout_pulse", timeout_err, 1);
    check("wd_timeout_idle", busy, 0);
    tick();
    check("wd_timeout_cleared", timeout_err, 0);
    check("wd_next_issued", issue_cnt, base + 2);
    flip_ack();
    check("wd_next_done", busy, 0);
    check("wd_pulse_count", to_cnt, 1);

    // Ack edge on the watchdog expiry cycle: completion wins
    base = issue_cnt;
    push(OP_INV, 8'h5A);
    wait_issue(base + 1);
    repeat (16) tick();
    check("race_pre_busy", busy, 1);
    ack_toggle = ~ack_toggle;
    tick();
    check("race_idle", busy, 0);
    check("race_no_timeout", timeout_err, 0);
    repeat (3) tick();
    check("race_pulse_count", to_cnt, 1);
    check("race_sb", sb.size(), 0);

    // Ack edge in IDLE is absorbed; reset mid WAIT_ACK drops the queue
    ic = issue_cnt;
    ack_toggle = 1'b1;
    repeat (3) tick();
    check("absorb_busy", busy, 0);
    check("absorb_issue", issue_cnt, ic);
    push(OP_NOP,  8'h10);
    push(OP_SHL2, 8'h20);
    push(OP_ROR2, 8'h30);
    push(OP_INV,  8'h40);
    check("pre_rst_count", fifo_count, 3);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    sb.delete();
    check("mid_rst_op_code", op_code, 0);
    check("mid_rst_data_in", data_in, 0);
    check("mid_rst_op_start", op_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_timeout", timeout_err, 0);
    check("mid_rst_count", fifo_count, 0);
    rst = 1'b0;
    ic = issue_cnt;
    tick();
    ack_toggle = 1'b0;
    repeat (8) tick();
    check("post_rst_no_issue", issue_cnt, ic);
    check("post_rst_busy", busy, 0);
    check("post_rst_no_timeout", to_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit observed=expired required=finish");
    $fatal(1, "time limit");
  end

endmodule
